// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared edge/center-aligned period counter, per-channel
// double-buffered duty levels that only change at a period boundary.
module pwm_multi #(
  parameter int                WIDTH  = 8,
  parameter int                NUM_CH = 3,
  parameter logic [NUM_CH-1:0] INVERT = '0,
  localparam int               CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              center,
  input  logic [WIDTH-1:0]  top,
  input  logic              wr_en,
  input  logic [CHW-1:0]    wr_ch,
  input  logic [WIDTH-1:0]  wr_level,
  output logic [NUM_CH-1:0] out,
  output logic              period_tick,
  output logic [WIDTH-1:0]  count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic             dir_down_reg, dir_down_next;
  logic [WIDTH-1:0] top_a_reg;
  logic             center_a_reg;
  logic             tick_reg;
  logic             boundary;

  // Disabled or top_a==0 fall through to the defaults: counter parked at 0, counting up.
  always_comb begin
    cnt_next      = '0;
    dir_down_next = 1'b0;
    if (enable && (top_a_reg != '0)) begin
      if (!center_a_reg) begin
        if (cnt_reg < top_a_reg) begin
          cnt_next = cnt_reg + ONE;
        end
      end else if (!dir_down_reg) begin
        if (cnt_reg < top_a_reg) begin
          cnt_next = cnt_reg + ONE;
        end else if (top_a_reg != ONE) begin
          cnt_next      = cnt_reg - ONE;
          dir_down_next = 1'b1;
        end
      end else if (cnt_reg > ONE) begin
        cnt_next      = cnt_reg - ONE;
        dir_down_next = 1'b1;
      end
    end
  end

  // A period ends whenever the counter is about to return to 0; disabled edges qualify too.
  assign boundary = (cnt_next == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg      <= '0;
      dir_down_reg <= 1'b0;
      top_a_reg    <= '1;
      center_a_reg <= 1'b0;
      tick_reg     <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      dir_down_reg <= dir_down_next;
      if (boundary) begin
        top_a_reg    <= top;
        center_a_reg <= center;
      end
      tick_reg <= enable && (cnt_reg == '0) && (!center_a_reg || !dir_down_reg);
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [WIDTH-1:0] shadow_reg;
    logic [WIDTH-1:0] active_reg;
    logic             ch_out_reg;

    // On a write that lands on a boundary, active still takes the old shadow value.
    always_ff @(posedge clk) begin
      if (reset) begin
        shadow_reg <= '0;
        active_reg <= '0;
        ch_out_reg <= INVERT[gi];
      end else begin
        if (wr_en && (wr_ch == CHW'(gi))) begin
          shadow_reg <= wr_level;
        end
        if (boundary) begin
          active_reg <= shadow_reg;
        end
        ch_out_reg <= INVERT[gi] ^ (enable && (cnt_reg < active_reg));
      end
    end

    assign out[gi] = ch_out_reg;
  end

  assign period_tick = tick_reg;
  assign count       = cnt_reg;

endmodule
